sensor_frame_tx: RTL and testbench

Reader-side companion to the sensor sample FIFO. It drains 16-bit samples through the FIFO's read port and emits them as framed byte packets on a valid/ready byte stream toward the host link (UART/SPI serializer). A frame starts when a full burst is buffered, on an explicit flush, or when a partial burst has waited too long.

---
 rtl/frame_pkg.sv | 17 +
 rtl/sensor_frame_tx.sv | 129 ++++++++++++
 tb/tb_sensor_frame_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame states and framing constants for sensor_frame_tx
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ID,
        ST_LEN,
        ST_DHI,
        ST_DLO,
        ST_CSUM
    } state_t;

    localparam logic [7:0] FRAME_SYNC     = 8'hA5;
    localparam int         FRAME_OVERHEAD = 4;

endpackage

// File: rtl/sensor_frame_tx.sv
// rtl/sensor_frame_tx.sv - drains FWFT sample FIFO into A5/id/len/payload/csum byte frames
module sensor_frame_tx
    import frame_pkg::*;
#(
    parameter int BURST_LEN      = 4,
    parameter int COUNT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [7:0]             sensor_id,
    output logic                   fifo_rd_en,
    input  logic [15:0]            fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [15:0]            frames_sent
);

    localparam int                     TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] BURST_C  = COUNT_WIDTH'(BURST_LEN);

    state_t        state, state_nxt;
    logic [7:0]    n_len;
    logic [7:0]    remaining;
    logic [7:0]    id_reg;
    logic [7:0]    lo_byte;
    logic [7:0]    csum;
    logic          flush_pend;
    logic [TW-1:0] tmo_cnt;

    logic       handshake;
    logic       have_data;
    logic       full_burst;
    logic       start;
    logic [7:0] n_start;

    assign handshake  = tx_valid && tx_ready;
    assign have_data  = (fifo_count != '0);
    assign full_burst = (fifo_count >= BURST_C);
    assign start      = (state == ST_IDLE) && enable &&
                        (full_burst || (flush_pend && have_data) || (tmo_cnt == TMO_LAST && have_data));
    assign n_start    = full_burst ? 8'(BURST_LEN) : 8'(fifo_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_HDR;
            ST_HDR:  if (handshake) state_nxt = ST_ID;
            ST_ID:   if (handshake) state_nxt = ST_LEN;
            ST_LEN:  if (handshake) state_nxt = ST_DHI;
            ST_DHI:  if (handshake) state_nxt = ST_DLO;
            ST_DLO:  if (handshake) state_nxt = (remaining == 8'd1) ? ST_CSUM : ST_DHI;
            ST_CSUM: if (handshake) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // DHI presents the FIFO head directly, so an empty FIFO there must stall rather than send garbage
    always_comb begin
        tx_valid   = (state != ST_IDLE) && !((state == ST_DHI) && fifo_empty);
        busy       = (state != ST_IDLE);
        fifo_rd_en = (state == ST_DHI) && tx_ready && !fifo_empty;
        tx_data    = 8'h00;
        case (state)
            ST_HDR:  tx_data = FRAME_SYNC;
            ST_ID:   tx_data = id_reg;
            ST_LEN:  tx_data = n_len;
            ST_DHI:  tx_data = fifo_rd_data[15:8];
            ST_DLO:  tx_data = lo_byte;
            ST_CSUM: tx_data = csum;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_len       <= '0;
            remaining   <= '0;
            id_reg      <= '0;
            lo_byte     <= '0;
            csum        <= '0;
            flush_pend  <= 1'b0;
            tmo_cnt     <= '0;
            frames_sent <= '0;
        end else begin
            if (start || (state == ST_IDLE && !have_data)) flush_pend <= 1'b0;
            if (flush)                                     flush_pend <= 1'b1;

            if (state == ST_IDLE && have_data && !full_burst && !start)
                tmo_cnt <= (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;

            if (start) begin
                n_len     <= n_start;
                remaining <= n_start;
                id_reg    <= sensor_id;
                csum      <= sensor_id ^ n_start;
            end

            if (state == ST_DHI && handshake) begin
                lo_byte <= fifo_rd_data[7:0];
                csum    <= csum ^ fifo_rd_data[15:8];
            end

            if (state == ST_DLO && handshake) begin
                csum      <= csum ^ lo_byte;
                remaining <= remaining - 8'd1;
            end

            if (state == ST_CSUM && handshake) frames_sent <= frames_sent + 16'd1;
        end
    end

    a_no_empty_dhi: assert property (@(posedge clk) disable iff (!rst_n) !(state == ST_DHI && fifo_empty));

endmodule

// File: tb/tb_sensor_frame_tx.sv
// tb/tb_sensor_frame_tx.sv - self-checking bench for sensor_frame_tx with an FWFT FIFO model
module tb_sensor_frame_tx;

    localparam int BURST = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  sensor_id = 8'h00;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [15:0] frames_sent;

    always #5 clk = ~clk;

    sensor_frame_tx #(
        .BURST_LEN(BURST),
        .COUNT_WIDTH(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .flush(flush),
        .sensor_id(sensor_id),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .frames_sent(frames_sent)
    );

    // FWFT FIFO model: pushes come from the stimulus, pops from the DUT strobe
    logic [15:0] mem [0:255];
    logic [7:0]  head = 8'd0;
    logic [7:0]  tail = 8'd0;
    int          pops = 0;
    int          rd_empty_err = 0;

    assign fifo_count   = 4'(tail - head);
    assign fifo_empty   = (tail == head);
    assign fifo_rd_data = mem[head];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) rd_empty_err <= rd_empty_err + 1;
            else begin
                head <= head + 8'd1;
                pops <= pops + 1;
            end
        end
    end

    logic [7:0] rx_q[$];
    int         stall_err = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && (!tx_valid || tx_data !== pd)) stall_err++;
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
        end
    end

    int          checks = 0;
    int          fails = 0;
    int          rd_idx = 0;
    int          exp_pops = 0;
    int          exp_frames = 0;
    int          last_cycles = 0;
    int          c = 0;
    bit          rnd = 1'b0;
    logic [15:0] ref_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push(input logic [15:0] s);
        mem[tail] = s;
        tail      = tail + 8'd1;
        ref_q.push_back(s);
    endtask

    task automatic wait_valid(output int cyc, input int budget);
        cyc = 0;
        while (!tx_valid && cyc < budget) begin
            step();
            cyc++;
        end
    endtask

    // Reference frame built straight from the byte-level frame definition
    task automatic expect_frame(input string tag, input logic [7:0] id, input int n, input int budget);
        logic [7:0]  exp[$];
        logic [7:0]  cs;
        logic [15:0] s;
        int          cyc;
        exp = {8'hA5, id, 8'(n)};
        cs  = id ^ 8'(n);
        for (int i = 0; i < n; i++) begin
            s = ref_q.pop_front();
            exp.push_back(s[15:8]);
            exp.push_back(s[7:0]);
            cs = cs ^ s[15:8] ^ s[7:0];
        end
        exp.push_back(cs);
        cyc = 0;
        while (rx_q.size() < rd_idx + exp.size() && cyc < budget) begin
            step();
            cyc++;
        end
        last_cycles = cyc;
        chk({tag, "_len"}, 32'(rx_q.size() - rd_idx), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (rd_idx + i < rx_q.size()) chk({tag, "_byte"}, 32'(rx_q[rd_idx + i]), 32'(exp[i]));
        rd_idx = rx_q.size();
        exp_pops   += n;
        exp_frames += 1;
        chk({tag, "_pops"}, 32'(pops), 32'(exp_pops));
        chk({tag, "_frames"}, 32'(frames_sent), 32'(exp_frames));
    endtask

    initial begin
        step();
        step();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        rst_n = 1'b1;
        step();

        // Full burst, ready always high, sensor_id changed after start
        enable    = 1'b1;
        sensor_id = 8'h07;
        push(16'h1234); push(16'h5678); push(16'h9ABC); push(16'hDEF0);
        step();
        chk("t1_start_valid", 32'(tx_valid), 32'd1);
        chk("t1_start_sync", 32'(tx_data), 32'hA5);
        chk("t1_start_busy", 32'(busy), 32'd1);
        sensor_id = 8'hFF;
        expect_frame("t1", 8'h07, 4, 60);
        chk("t1_duration", 32'(last_cycles), 32'(4 + 2 * 4));
        chk("t1_idle_after", 32'(busy), 32'd0);

        // Partial burst released by the timeout
        sensor_id = 8'($urandom);
        push(16'($urandom)); push(16'($urandom));
        wait_valid(c, 100);
        chk("t2_timeout_latency", 32'(c), 32'(TMO));
        expect_frame("t2", sensor_id, 2, 60);

        // Flush of a single sample
        sensor_id = 8'($urandom);
        push(16'($urandom));
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_valid(c, 20);
        chk("t3_flush_latency", 32'(c), 32'd1);
        expect_frame("t3", sensor_id, 1, 40);

        // Flush with nothing buffered must be forgotten
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t3_empty_flush_busy", 32'(busy), 32'd0);
        chk("t3_empty_flush_bytes", 32'(rx_q.size() - rd_idx), 32'd0);
        push(16'($urandom));
        step();
        step();
        chk("t3_pend_cleared_busy", 32'(busy), 32'd0);
        chk("t3_pend_cleared_valid", 32'(tx_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_frame("t3b", sensor_id, 1, 40);

        // Random backpressure over a full burst
        sensor_id = 8'($urandom);
        for (int i = 0; i < 4; i++) push(16'($urandom));
        rnd = 1'b1;
        expect_frame("t4", sensor_id, 4, 400);
        rnd = 1'b0;
        step();
        chk("t4_stall_stable", 32'(stall_err), 32'd0);

        // Six samples: full burst, then remainder after the timeout
        sensor_id = 8'($urandom);
        for (int i = 0; i < 6; i++) push(16'($urandom));
        expect_frame("t5a", sensor_id, 4, 60);
        chk("t5_idle_gap", 32'(busy), 32'd0);
        wait_valid(c, 100);
        chk("t5_second_latency", 32'(c), 32'(TMO));
        expect_frame("t5b", sensor_id, 2, 60);

        // Reset while sending the low byte of the first sample
        sensor_id = 8'($urandom);
        for (int i = 0; i < 4; i++) push(16'($urandom));
        c = 0;
        while (rx_q.size() - rd_idx < 4 && c < 40) begin
            step();
            c++;
        end
        chk("t6_reached_dlo", 32'(rx_q.size() - rd_idx), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(tx_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t6_rst_frames", 32'(frames_sent), 32'd0);
        void'(ref_q.pop_front());
        exp_pops  += 1;
        exp_frames = 0;
        step();
        step();
        rst_n  = 1'b1;
        rd_idx = rx_q.size();
        chk("t6_no_pop_in_reset", 32'(pops), 32'(exp_pops));
        chk("t6_idle_after_reset", 32'(busy), 32'd0);
        wait_valid(c, 100);
        chk("t6_resume_latency", 32'(c), 32'(TMO));
        expect_frame("t6", sensor_id, 3, 60);

        chk("fifo_pop_when_empty", 32'(rd_empty_err), 32'd0);
        chk("final_stall_stable", 32'(stall_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
